// File: rtl/hazard_ctrl_if.sv
// D-stage decoder <-> hazard controller bundle: decoded producer/consumer info
// in, stall / forward selects / HI/LO busy out.
interface hazard_ctrl_if #(
  parameter int NSTAGE = 3,
  parameter int AW     = 6,
  parameter int TW     = 3
);
  localparam int FW = $clog2(NSTAGE + 1);

  logic [AW-1:0] d_anew;
  logic [TW-1:0] d_tnew;
  logic [AW-1:0] d_ause1;
  logic [AW-1:0] d_ause2;
  logic [TW-1:0] d_tuse1;
  logic [TW-1:0] d_tuse2;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          stall;
  logic [FW-1:0] fwd1_sel;
  logic [FW-1:0] fwd2_sel;
  logic          md_busy;

  modport master (
    output d_anew, d_tnew, d_ause1, d_ause2, d_tuse1, d_tuse2,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd1_sel, fwd2_sel, md_busy
  );

  modport slave (
    input  d_anew, d_tnew, d_ause1, d_ause2, d_tuse1, d_tuse2,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd1_sel, fwd2_sel, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: scoreboard of in-flight producers in E..N plus a
// HI/LO busy counter; drives D-stage stall and per-operand forward selects.

// One source operand: youngest matching producer decides forward vs. stall.
module hazard_opnd #(
  parameter int NSTAGE = 3,
  parameter int AW     = 6,
  parameter int TW     = 3,
  parameter int FW     = 2
) (
  input  logic [NSTAGE-1:0][AW-1:0] ent_addr,
  input  logic [NSTAGE-1:0][TW-1:0] ent_tnew,
  input  logic [AW-1:0]             ause,
  input  logic [TW-1:0]             tuse,
  output logic                      hazard,
  output logic [FW-1:0]             sel
);
  logic          hit;
  logic [FW-1:0] k_hit;
  logic [TW-1:0] t_hit;
  logic          ause_ok;

  // HI/LO pseudo-registers are handled by the busy counter, not the scoreboard.
  assign ause_ok = (ause != '0) && !ause[AW-1];

  always_comb begin
    hit   = 1'b0;
    k_hit = '0;
    t_hit = '0;
    // Walk oldest to youngest so the youngest match overwrites.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (ause_ok && (ent_addr[k] == ause)) begin
        hit   = 1'b1;
        k_hit = FW'(k + 1);
        t_hit = ent_tnew[k];
      end
    end
    hazard = hit && (t_hit > tuse);
    sel    = (hit && !hazard) ? k_hit : '0;
  end
endmodule

module hazard_ctrl #(
  parameter int NSTAGE   = 3,
  parameter int AW       = 6,
  parameter int TW       = 3,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  localparam int FW   = $clog2(NSTAGE + 1);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Index 0 is E; index k-1 holds tracked stage k.
  logic [NSTAGE-1:0][AW-1:0] ent_addr_q, ent_addr_d;
  logic [NSTAGE-1:0][TW-1:0] ent_tnew_q, ent_tnew_d;
  logic [CW-1:0]             md_cnt_q, md_cnt_d;

  logic [1:0][AW-1:0] ause;
  logic [1:0][TW-1:0] tuse;
  logic [1:0]         hz;
  logic [1:0][FW-1:0] sel;
  logic               md_busy;
  logic               md_hz;
  logic               stall;

  assign ause = {hif.d_ause2, hif.d_ause1};
  assign tuse = {hif.d_tuse2, hif.d_tuse1};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    hazard_opnd #(
      .NSTAGE (NSTAGE),
      .AW     (AW),
      .TW     (TW),
      .FW     (FW)
    ) u_opnd (
      .ent_addr (ent_addr_q),
      .ent_tnew (ent_tnew_q),
      .ause     (ause[g]),
      .tuse     (tuse[g]),
      .hazard   (hz[g]),
      .sel      (sel[g])
    );
  end

  assign md_busy = (md_cnt_q != '0);
  // Also serialises back-to-back mult/div, since start implies use.
  assign md_hz   = hif.d_md_use & md_busy;
  assign stall   = (|hz) | md_hz;

  assign hif.stall    = stall;
  assign hif.fwd1_sel = sel[0];
  assign hif.fwd2_sel = sel[1];
  assign hif.md_busy  = md_busy;

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_tnew_d = ent_tnew_q;
    // A stalled D slot turns into a bubble in E; older stages always advance.
    ent_addr_d[0] = stall ? '0 : hif.d_anew;
    ent_tnew_d[0] = stall ? '0 : sat_dec(hif.d_tnew);
    for (int k = 1; k < NSTAGE; k++) begin
      ent_addr_d[k] = ent_addr_q[k-1];
      ent_tnew_d[k] = sat_dec(ent_tnew_q[k-1]);
    end
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (hif.d_md_start && !stall)
      md_cnt_d = hif.d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_addr_q <= '0;
      ent_tnew_q <= '0;
      md_cnt_q   <= '0;
    end else begin
      ent_addr_q <= ent_addr_d;
      ent_tnew_q <= ent_tnew_d;
      md_cnt_q   <= md_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations, then
// random traffic checked each cycle against a producer-history model.
module tb_hazard_ctrl;
  localparam int NSTAGE   = 3;
  localparam int AW       = 6;
  localparam int TW       = 3;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.NSTAGE(NSTAGE), .AW(AW), .TW(TW)) hif ();

  hazard_ctrl #(
    .NSTAGE   (NSTAGE),
    .AW       (AW),
    .TW       (TW),
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: history of what entered E on each edge (youngest first), with the
  // Tnew it had at D; its remaining Tnew after k edges is max(tnew-k, 0).
  typedef struct { int addr; int tnew; } prod_t;
  prod_t hist[$];
  int    ec   = 0;
  int    md_s = -1;
  int    md_dur = 0;

  function automatic void m_op(input int a, input int tu, output bit hz, output int sel);
    int rem;
    hz = 0; sel = 0;
    if (a == 0 || a >= (1 << (AW - 1))) return;
    for (int k = 1; k <= hist.size(); k++) begin
      if (hist[k-1].addr == a) begin
        rem = hist[k-1].tnew - k;
        if (rem < 0) rem = 0;
        hz  = (rem > tu);
        sel = hz ? 0 : k;
        return;
      end
    end
  endfunction

  function automatic bit m_busy();
    return (md_s >= 0) && ((ec - md_s) < md_dur);
  endfunction

  function automatic bit m_stall();
    bit h1, h2; int s1, s2;
    m_op(int'(hif.d_ause1), int'(hif.d_tuse1), h1, s1);
    m_op(int'(hif.d_ause2), int'(hif.d_tuse2), h2, s2);
    return h1 | h2 | (hif.d_md_use && m_busy());
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      ec = 0; md_s = -1; md_dur = 0;
    end else begin
      bit st;
      prod_t p;
      st = m_stall();
      p.addr = st ? 0 : int'(hif.d_anew);
      p.tnew = st ? 0 : int'(hif.d_tnew);
      hist.push_front(p);
      if (hist.size() > NSTAGE) void'(hist.pop_back());
      ec++;
      if (hif.d_md_start && !st) begin
        md_s   = ec;
        md_dur = hif.d_md_div ? DIV_CYC : MULT_CYC;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      bit h1, h2; int s1, s2;
      m_op(int'(hif.d_ause1), int'(hif.d_tuse1), h1, s1);
      m_op(int'(hif.d_ause2), int'(hif.d_tuse2), h2, s2);
      chk("cmp_stall",   int'(hif.stall),    int'(m_stall()));
      chk("cmp_fwd1",    int'(hif.fwd1_sel), s1);
      chk("cmp_fwd2",    int'(hif.fwd2_sel), s2);
      chk("cmp_md_busy", int'(hif.md_busy),  int'(m_busy()));
    end
  end

  task automatic idle();
    hif.d_anew = '0; hif.d_tnew = '0;
    hif.d_ause1 = '0; hif.d_ause2 = '0;
    hif.d_tuse1 = '0; hif.d_tuse2 = '0;
    hif.d_md_start = 1'b0; hif.d_md_div = 1'b0; hif.d_md_use = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic md_test(input bit div, input int exp_cyc, input string tag);
    int n_st, n_busy;
    idle();
    hif.d_md_start = 1'b1; hif.d_md_use = 1'b1; hif.d_md_div = div;
    @(negedge clk);
    chk({tag, "_start_stall"}, int'(hif.stall), 0);
    tick();
    idle();
    hif.d_md_use = 1'b1;
    n_st = 0; n_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hif.md_busy) n_busy++;
      if (!hif.stall) break;
      n_st++;
      tick();
    end
    chk({tag, "_stall_cycles"}, n_st, exp_cyc);
    chk({tag, "_busy_cycles"}, n_busy, exp_cyc);
    tick();
    @(negedge clk);
    chk({tag, "_busy_after"}, int'(hif.md_busy), 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", int'(hif.stall),    0);
    chk("rst_fwd1",  int'(hif.fwd1_sel), 0);
    chk("rst_fwd2",  int'(hif.fwd2_sel), 0);
    chk("rst_busy",  int'(hif.md_busy),  0);
    reset = 1'b0;
    tick();

    // Load-use: lw $5 then addu using $5 at Tuse=1.
    hif.d_anew = 6'd5; hif.d_tnew = 3'd3;
    @(negedge clk); chk("t1_lw_stall", int'(hif.stall), 0);
    tick();
    hif.d_anew = 6'd6; hif.d_tnew = 3'd2; hif.d_ause1 = 6'd5; hif.d_tuse1 = 3'd1;
    @(negedge clk); chk("t1_stall", int'(hif.stall), 1);
    tick();
    @(negedge clk);
    chk("t1_stall_clear", int'(hif.stall), 0);
    chk("t1_fwd1", int'(hif.fwd1_sel), 2);
    tick();

    // Register 0 never matches, even with a pending tnew.
    idle(); hif.d_tnew = 3'd3;
    tick();
    idle();
    @(negedge clk);
    chk("t2_stall", int'(hif.stall), 0);
    chk("t2_fwd1", int'(hif.fwd1_sel), 0);
    tick();

    // Youngest producer wins.
    idle(); hif.d_anew = 6'd7; hif.d_tnew = 3'd2;
    tick(); tick();
    idle(); hif.d_ause2 = 6'd7; hif.d_tuse2 = 3'd2;
    @(negedge clk);
    chk("t3_fwd2", int'(hif.fwd2_sel), 1);
    chk("t3_stall", int'(hif.stall), 0);
    tick();

    md_test(1'b0, MULT_CYC, "t4_mult");
    md_test(1'b1, DIV_CYC,  "t4_div");

    // Bubble on stall while the producer keeps aging.
    idle(); hif.d_anew = 6'd9; hif.d_tnew = 3'd3;
    tick();
    idle(); hif.d_ause1 = 6'd9; hif.d_tuse1 = 3'd0;
    @(negedge clk); chk("t5_stall1", int'(hif.stall), 1);
    tick();
    @(negedge clk); chk("t5_stall2", int'(hif.stall), 1);
    tick();
    @(negedge clk);
    chk("t5_stall3", int'(hif.stall), 0);
    chk("t5_fwd1", int'(hif.fwd1_sel), 3);
    tick();

    // Async reset mid-operation.
    idle(); hif.d_tnew = 3'd3;
    hif.d_anew = 6'd10; tick();
    hif.d_anew = 6'd11; tick();
    hif.d_anew = 6'd12; tick();
    idle(); hif.d_md_start = 1'b1; hif.d_md_use = 1'b1; hif.d_md_div = 1'b1;
    tick();
    idle(); hif.d_md_use = 1'b1; hif.d_ause1 = 6'd12; hif.d_ause2 = 6'd11;
    @(negedge clk);
    chk("t6_pre_stall", int'(hif.stall), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_stall", int'(hif.stall),    0);
    chk("t6_rst_fwd1",  int'(hif.fwd1_sel), 0);
    chk("t6_rst_fwd2",  int'(hif.fwd2_sel), 0);
    chk("t6_rst_busy",  int'(hif.md_busy),  0);
    #2 reset = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_after_stall", int'(hif.stall), 0);
    chk("t6_after_busy",  int'(hif.md_busy), 0);
    tick();

    // Random traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      bit st;
      hif.d_anew  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 7));
      hif.d_tnew  = TW'($urandom_range(0, 3));
      hif.d_ause1 = ($urandom_range(0, 9) == 0) ? AW'(32 + $urandom_range(0, 31))
                                                : AW'($urandom_range(0, 7));
      hif.d_ause2 = ($urandom_range(0, 9) == 0) ? AW'(32 + $urandom_range(0, 31))
                                                : AW'($urandom_range(0, 7));
      hif.d_tuse1 = TW'($urandom_range(0, 3));
      hif.d_tuse2 = TW'($urandom_range(0, 3));
      st = ($urandom_range(0, 19) == 0);
      hif.d_md_start = st;
      hif.d_md_div   = $urandom_range(0, 1) == 1;
      hif.d_md_use   = st | ($urandom_range(0, 5) == 0);
      tick();
    end
    idle();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
